module_nibble_packer: RTL and testbench
=======================================

# module_nibble_packer

Assembles a 16-bit word from individually strobed 4-bit digits, calculator-style: each new digit enters at the least-significant nibble and older digits shift up. It is the write side of the display datapath and feeds the 16-bit `in_data` bus that the 4:1 nibble multiplexer scans for display. Supports clear, backspace and an explicit commit handshake that publishes the finished word with a one-cycle valid pulse.

## Interface
- `NIBBLES`, 4: number of 4-bit digits per word (word width = 4*NIBBLES); fixed at 4 for this design.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `digit_in`  in  4  digit value; any value 0x0–0xF is accepted.
- `digit_valid`  in  1  strobe; `digit_in` is sampled on each cycle this is high.
- `backspace`  in  1  strobe; removes the most recent digit.
- `clear`  in  1  strobe; discards all entered digits.
- `commit`  in  1  strobe; publishes the working word.
- `acc_data`  out  16  live working word, which mirrors the entry in progress.
- `out_data`  out  16  last committed word; connects to the mux `in_data`.
- `count`  out  3  digits currently held, 0..4.
- `full`  out  1  high when `count == 4`.
- `word_valid`  out  1  one-cycle pulse when `out_data` updates.
- `overflow`  out  1  one-cycle pulse when a digit is rejected because the block is full.

## Operation
- States:
  - EMPTY: `count == 0`.
  - FILLING: `count` is 1..3.
  - FULL: `count == 4`.
- State is derived from `count`. `full` is a registered flag equal to (state == FULL).
- Strobes are level-sampled every cycle. Holding a strobe high for N cycles is N events; upstream debouncing and edge detection are outside this block.
- Priority per cycle, highest first: `rst`, `clear`, `commit`, `backspace`, `digit_valid`. Only the highest-priority active request acts; the others are dropped.
- Digit entry when not FULL:
  - `acc_data <= {acc_data[11:0], digit_in}`
  - `count <= count + 1`
- Digit entry when FULL: `acc_data` and `count` stay unchanged and `overflow` pulses for 1 cycle.
- Backspace when `count > 0`:
  - `acc_data <= {4'h0, acc_data[15:4]}`
  - `count <= count - 1`
- Backspace when EMPTY: no effect and no flag.
- Clear: `acc_data <= 0` and `count <= 0`. `out_data` is unchanged.
- Commit when `count > 0`:
  - `out_data <= acc_data`
  - `word_valid <= 1`
  - `acc_data <= 0`
  - `count <= 0`
- Commit when EMPTY: no effect. `word_valid` stays low and `out_data` is unchanged.
- Unused upper nibbles of a partial word are zero. For example, committing 2 digits {0x3, 0x7} yields `out_data = 16'h0037`.
- `out_data` holds its value until the next valid commit or reset.

## Timing
- Reset values:
  - `acc_data = 0`
  - `out_data = 0`
  - `count = 0`
  - `full = 0`
  - `word_valid = 0`
  - `overflow = 0`
  - state EMPTY
- Reset takes effect immediately and asynchronously. An entry or commit in progress is lost, and no `word_valid` is issued for it.
- Reset is released synchronously to `clk`; the first sampling edge is the first rising edge after `rst` falls.
- Latency is 1 cycle for all operations. A strobe sampled at edge k has its effect visible on every output after edge k.
- `word_valid` and `overflow` are high for exactly the one cycle following the triggering edge, then return to 0 unless retriggered.
- Back-to-back operations are supported with no dead cycles:
  - a commit at edge k followed by a digit at edge k+1 starts a new word;
  - a commit followed by commit leaves the second commit ignored (EMPTY).
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset, then digits 0x1, 0x2, 0x3, 0x4 on consecutive cycles, then commit -> `acc_data` goes 0x0001, 0x0012, 0x0123, 0x1234 and `full = 1`. After commit: `out_data = 0x1234`, a single-cycle `word_valid`, `count = 0`, `acc_data = 0`.
- When FULL (0x1234), send digit 0x9 -> `overflow` pulses for 1 cycle and `acc_data` stays 0x1234. Then backspace -> `acc_data = 0x0123`, `count = 3`. Then digit 0x9 -> `acc_data = 0x1239`.
- Enter 0xA, 0xB, then clear, then commit -> after clear `acc_data = 0` and `count = 0`. The commit is ignored: `word_valid` stays 0 and `out_data` keeps its prior value.
- In a single cycle, assert `digit_valid` (0x5), `backspace` and `commit` with `acc_data = 0x0042` -> the commit wins: `out_data = 0x0042`, `word_valid = 1`, `acc_data = 0`. Then, asserting `clear` and `commit` together on a 1-digit entry results in a clear with no `word_valid`.
- Enter 0x7, 0x8, 0x9, then assert `rst` asynchronously mid-cycle -> all outputs are 0 immediately, with no clock edge required. After release, digit 0xC gives `acc_data = 0x000C`.
- Backspace when EMPTY, then commit of one digit 0xF, then an immediate digit 0x2 on the next cycle -> no change for the backspace. After the commit, `out_data = 0x000F`. One cycle later `acc_data = 0x0002`, `count = 1`, and `out_data` is still 0x000F.

Source files
------------

// File: rtl/module_nibble_packer.sv
// module_nibble_packer
// Calculator-style word assembler for the display datapath. Each strobed
// 4-bit digit enters at the least-significant nibble while older digits move
// up. A backspace drops the newest digit, a clear discards the entry, and a
// commit copies the entry to out_data with a one-cycle word_valid pulse.
// Only the highest-priority request in a cycle acts. The order, highest
// first, is clear, commit, backspace, digit_valid.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   digit_in    digit value 0x0..0xF, sampled while digit_valid is high
//   digit_valid digit strobe
//   backspace   remove most recent digit
//   clear       discard all entered digits
//   commit      publish the working word
//   acc_data    live working word
//   out_data    last committed word (feeds the nibble mux in_data)
//   count       digits currently held, 0..NIBBLES
//   full        registered, high when count == NIBBLES
//   word_valid  one-cycle pulse when out_data updates
//   overflow    one-cycle pulse when a digit is rejected because full
module module_nibble_packer #(
  parameter int NIBBLES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3:0]                     digit_in,
  input  logic                           digit_valid,
  input  logic                           backspace,
  input  logic                           clear,
  input  logic                           commit,
  output logic [4*NIBBLES-1:0]           acc_data,
  output logic [4*NIBBLES-1:0]           out_data,
  output logic [$clog2(NIBBLES+1)-1:0]   count,
  output logic                           full,
  output logic                           word_valid,
  output logic                           overflow
);

  localparam int DATA_W = 4 * NIBBLES;
  localparam int CNT_W  = $clog2(NIBBLES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NIBBLES);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } state_t;

  state_t state;

  logic [DATA_W-1:0] acc_p0;
  logic [DATA_W-1:0] out_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              full_p0;
  logic              vld_p0;
  logic              ovf_p0;

  logic [DATA_W-1:0] acc_p1;
  logic [DATA_W-1:0] out_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic              full_p1;
  logic              vld_p1;
  logic              ovf_p1;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] acc,
                                                 input logic [3:0]        d);
    return {acc[DATA_W-5:0], d};
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] acc);
    return {4'h0, acc[DATA_W-1:4]};
  endfunction

  // The state is decoded from the registered count, so it never disagrees with count.
  always_comb begin
    if (cnt_p1 == '0)
      state = EMPTY;
    else if (cnt_p1 == CNT_FULL)
      state = FULL;
    else
      state = FILLING;
  end

  // Stage p0: next-state and strobe decode
  always_comb begin
    acc_p0 = acc_p1;
    out_p0 = out_p1;
    cnt_p0 = cnt_p1;
    vld_p0 = 1'b0;
    ovf_p0 = 1'b0;
    if (clear) begin
      acc_p0 = '0;
      cnt_p0 = '0;
    end else if (commit) begin
      if (state != EMPTY) begin
        out_p0 = acc_p1;
        vld_p0 = 1'b1;
        acc_p0 = '0;
        cnt_p0 = '0;
      end
    end else if (backspace) begin
      if (state != EMPTY) begin
        acc_p0 = shift_out(acc_p1);
        cnt_p0 = cnt_p1 - 1'b1;
      end
    end else if (digit_valid) begin
      if (state == FULL) begin
        ovf_p0 = 1'b1;
      end else begin
        acc_p0 = shift_in(acc_p1, digit_in);
        cnt_p0 = cnt_p1 + 1'b1;
      end
    end
    full_p0 = (cnt_p0 == CNT_FULL);
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1  <= '0;
      out_p1  <= '0;
      cnt_p1  <= '0;
      full_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      ovf_p1  <= 1'b0;
    end else begin
      acc_p1  <= acc_p0;
      out_p1  <= out_p0;
      cnt_p1  <= cnt_p0;
      full_p1 <= full_p0;
      vld_p1  <= vld_p0;
      ovf_p1  <= ovf_p0;
    end
  end

  assign acc_data   = acc_p1;
  assign out_data   = out_p1;
  assign count      = cnt_p1;
  assign full       = full_p1;
  assign word_valid = vld_p1;
  assign overflow   = ovf_p1;

endmodule

// File: tb/tb_module_nibble_packer.sv
module tb_module_nibble_packer;

  logic        clk;
  logic        rst;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        backspace;
  logic        clear;
  logic        commit;
  logic [15:0] acc_data;
  logic [15:0] out_data;
  logic [2:0]  count;
  logic        full;
  logic        word_valid;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  module_nibble_packer #(.NIBBLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .backspace   (backspace),
    .clear       (clear),
    .commit      (commit),
    .acc_data    (acc_data),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .word_valid  (word_valid),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One cycle: drive strobes at the falling edge, return 1 time unit after the rising edge.
  task automatic op(input logic clr, input logic cmt, input logic bs,
                    input logic dv, input logic [3:0] d);
    @(negedge clk);
    clear = clr; commit = cmt; backspace = bs; digit_valid = dv; digit_in = d;
    @(posedge clk);
    #1;
    clear = 1'b0; commit = 1'b0; backspace = 1'b0; digit_valid = 1'b0; digit_in = 4'h0;
  endtask

  task automatic digit(input logic [3:0] d);
    op(1'b0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".acc"},  acc_data,   32'h0);
    check({tag, ".out"},  out_data,   32'h0);
    check({tag, ".cnt"},  count,      32'h0);
    check({tag, ".full"}, full,       32'h0);
    check({tag, ".wv"},   word_valid, 32'h0);
    check({tag, ".ovf"},  overflow,   32'h0);
  endtask

  initial begin
    rst = 1'b1; digit_in = 4'h0; digit_valid = 1'b0;
    backspace = 1'b0; clear = 1'b0; commit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Four digits then commit
    digit(4'h1); check("d1.acc", acc_data, 32'h0001); check("d1.cnt", count, 32'd1);
    digit(4'h2); check("d2.acc", acc_data, 32'h0012);
    digit(4'h3); check("d3.acc", acc_data, 32'h0123); check("d3.full", full, 32'd0);
    digit(4'h4); check("d4.acc", acc_data, 32'h1234); check("d4.full", full, 32'd1);
    check("d4.cnt", count, 32'd4);
    op(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("cm1.out", out_data, 32'h1234); check("cm1.wv", word_valid, 32'd1);
    check("cm1.acc", acc_data, 32'h0);    check("cm1.cnt", count, 32'd0);
    check("cm1.full", full, 32'd0);
    idle();
    check("cm1.wv_low", word_valid, 32'd0); check("cm1.hold", out_data, 32'h1234);

    // Overflow when full, then backspace and re-entry
    digit(4'h1); digit(4'h2); digit(4'h3); digit(4'h4);
    digit(4'h9);
    check("ovf.pulse", overflow, 32'd1); check("ovf.acc", acc_data, 32'h1234);
    check("ovf.cnt", count, 32'd4);
    idle();
    check("ovf.low", overflow, 32'd0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("bs.acc", acc_data, 32'h0123); check("bs.cnt", count, 32'd3);
    check("bs.full", full, 32'd0);
    digit(4'h9);
    check("re.acc", acc_data, 32'h1239); check("re.full", full, 32'd1);
    check("re.ovf", overflow, 32'd0);

    // Clear then commit on an empty entry
    op(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    digit(4'hA); digit(4'hB);
    check("ab.acc", acc_data, 32'h00AB);
    op(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    check("clr.acc", acc_data, 32'h0); check("clr.cnt", count, 32'd0);
    check("clr.out", out_data, 32'h1234);
    op(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("cmE.wv", word_valid, 32'd0); check("cmE.out", out_data, 32'h1234);

    // Priority: commit beats backspace and digit; clear beats commit
    digit(4'h4); digit(4'h2);
    op(1'b0, 1'b1, 1'b1, 1'b1, 4'h5);
    check("pri.out", out_data, 32'h0042); check("pri.wv", word_valid, 32'd1);
    check("pri.acc", acc_data, 32'h0);
    digit(4'h1);
    check("pri2.wv_low", word_valid, 32'd0);
    op(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("pri2.acc", acc_data, 32'h0); check("pri2.wv", word_valid, 32'd0);
    check("pri2.out", out_data, 32'h0042); check("pri2.cnt", count, 32'd0);

    // Asynchronous reset mid-cycle
    digit(4'h7); digit(4'h8); digit(4'h9);
    check("pre_rst.acc", acc_data, 32'h0789);
    #2 rst = 1'b1;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst = 1'b0;
    digit(4'hC);
    check("post_rst.acc", acc_data, 32'h000C); check("post_rst.cnt", count, 32'd1);
    check("post_rst.out", out_data, 32'h0);

    // Backspace on empty, single-digit commit, back-to-back digit
    op(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    op(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    check("bsE.acc", acc_data, 32'h0); check("bsE.cnt", count, 32'd0);
    check("bsE.ovf", overflow, 32'd0);
    digit(4'hF);
    op(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("cmF.out", out_data, 32'h000F); check("cmF.wv", word_valid, 32'd1);
    digit(4'h2);
    check("b2b.acc", acc_data, 32'h0002); check("b2b.cnt", count, 32'd1);
    check("b2b.out", out_data, 32'h000F); check("b2b.wv", word_valid, 32'd0);

    // Commit followed by commit: the second is ignored
    op(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("cc1.out", out_data, 32'h0002); check("cc1.wv", word_valid, 32'd1);
    op(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    check("cc2.wv", word_valid, 32'd0); check("cc2.out", out_data, 32'h0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
